// File: rtl/bcd2b_seq.sv
// bcd2b_seq: iterative BCD-to-binary converter (reverse double-dabble).
// Converts one bit per clock; WIDTH shift steps per word, then a one-cycle
// result pulse.
// Optional feature macro: B2BCD_ERR_CHECK_EN builds the invalid-digit flag
// (out_err). Without it, out_err is tied low.
module bcd2b_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DIGIT*4-1:0]   BCD_code,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     Binary_code,
  output logic                 out_ovf,
  output logic                 out_err
);

  localparam int BCD_W = DIGIT * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [BCD_W-1:0]       bcd_reg;
  logic [WIDTH-1:0]       bin_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [WIDTH-1:0]       bin_out_reg;
  logic                   ovf_reg;

  // One conversion step: shift the {bcd,bin} pair right, then correct digits.
  logic [BCD_W+WIDTH-1:0] pair_shift;
  logic [BCD_W-1:0]       bcd_shift;
  logic [BCD_W-1:0]       bcd_step;
  logic [WIDTH-1:0]       bin_step;
  logic                   last_step;
  logic                   accept;

  assign pair_shift = {bcd_reg, bin_reg} >> 1;
  assign bcd_shift  = pair_shift[BCD_W+WIDTH-1:WIDTH];
  assign bin_step   = pair_shift[WIDTH-1:0];
  assign last_step  = (cnt_reg == CNT_W'(WIDTH - 1));
  assign accept     = (state_reg == IDLE) && in_valid;

  // Each digit that lands at 8 or above after the shift is pulled back by 3;
  // digits are corrected independently, no borrow between them.
  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_digit_fix
      assign bcd_step[gi*4 +: 4] = (bcd_shift[gi*4 +: 4] >= 4'd8)
                                   ? (bcd_shift[gi*4 +: 4] - 4'd3)
                                   : bcd_shift[gi*4 +: 4];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CONV;
      end
      CONV: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift datapath, step counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg     <= '0;
      bin_reg     <= '0;
      cnt_reg     <= '0;
      bin_out_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            bcd_reg <= BCD_code;
            bin_reg <= '0;
            cnt_reg <= '0;
          end
        end
        CONV: begin
          bcd_reg <= bcd_step;
          bin_reg <= bin_step;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_step) begin
            bin_out_reg <= bin_step;
            ovf_reg     <= |bcd_step;  // residue = value / 2^WIDTH
          end
        end
        DONE: begin
          // Results are only visible while out_valid is high.
          bin_out_reg <= '0;
          ovf_reg     <= 1'b0;
        end
        default: begin
          bin_out_reg <= '0;
          ovf_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign Binary_code = bin_out_reg;
  assign out_ovf     = ovf_reg;

`ifdef B2BCD_ERR_CHECK_EN
  logic [DIGIT-1:0] digit_bad;
  logic             err_in_reg;
  logic             err_out_reg;

  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_digit_chk
      assign digit_bad[gi] = (BCD_code[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  // Capture the invalid-digit flag at accept, publish it with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_in_reg  <= 1'b0;
      err_out_reg <= 1'b0;
    end else begin
      if (accept) err_in_reg <= |digit_bad;
      if (state_reg == CONV && last_step) err_out_reg <= err_in_reg;
      else if (state_reg == DONE)         err_out_reg <= 1'b0;
    end
  end

  assign out_err = err_out_reg;
`else
  assign out_err = 1'b0;
`endif

endmodule
